// File: rtl/calc_input_sequencer_if.sv
// Operand-entry bus between the input sequencer and its surroundings:
// raw user inputs, calculator result in, operands and display status out.
interface calc_input_sequencer_if;
    logic [3:0] sw;
    logic       btn_enter;
    logic       btn_clear;
    logic [3:0] calc_out;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] result;
    logic       result_valid;
    logic [1:0] phase;

    modport master (
        output sw, btn_enter, btn_clear, calc_out,
        input  a, b, op, result, result_valid, phase
    );

    modport slave (
        input  sw, btn_enter, btn_clear, calc_out,
        output a, b, op, result, result_valid, phase
    );
endinterface

// File: rtl/calc_input_sequencer.sv
// Keys operands A, B and the opcode in from switches, one ENTER per step,
// drives them to the calculator and latches its result for display.
module calc_input_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    calc_input_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0] sw_meta_reg;
    logic [3:0] sw_sync_reg;
    logic [1:0] btn_raw;
    logic [1:0] btn_meta_reg;
    logic [1:0] btn_sync_reg;
    logic [1:0] btn_db_reg;
    logic [1:0] btn_db_prev_reg;
    logic [1:0] btn_p;

    logic       enter_p;
    logic       clear_p;

    state_t     state_reg;
    logic [3:0] a_reg;
    logic [3:0] b_reg;
    logic [2:0] op_reg;
    logic [3:0] result_reg;
    logic       result_valid_reg;
    logic [1:0] phase_reg;

    assign btn_raw = {bus.btn_clear, bus.btn_enter};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_meta_reg  <= '0;
            sw_sync_reg  <= '0;
            btn_meta_reg <= '0;
            btn_sync_reg <= '0;
        end else begin
            sw_meta_reg  <= bus.sw;
            sw_sync_reg  <= sw_meta_reg;
            btn_meta_reg <= btn_raw;
            btn_sync_reg <= btn_meta_reg;
        end
    end

    // One debouncer per button: the level flips only after it has disagreed
    // with the accepted level for DEBOUNCE_CYCLES consecutive cycles.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg             <= '0;
                    btn_db_reg[gi]      <= 1'b0;
                    btn_db_prev_reg[gi] <= 1'b0;
                end else begin
                    btn_db_prev_reg[gi] <= btn_db_reg[gi];
                    if (btn_sync_reg[gi] == btn_db_reg[gi]) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        cnt_reg        <= '0;
                        btn_db_reg[gi] <= btn_sync_reg[gi];
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign btn_p[gi] = btn_db_reg[gi] & ~btn_db_prev_reg[gi];
        end
    endgenerate

    assign enter_p = btn_p[0];
    assign clear_p = btn_p[1];

    always_ff @(posedge clk) begin
        if (!rst_n || clear_p) begin
            state_reg        <= S_A;
            a_reg            <= '0;
            b_reg            <= '0;
            op_reg           <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            phase_reg        <= 2'b00;
        end else begin
            case (state_reg)
                S_A: begin
                    if (enter_p) begin
                        a_reg     <= sw_sync_reg;
                        state_reg <= S_B;
                        phase_reg <= 2'b01;
                    end
                end
                S_B: begin
                    if (enter_p) begin
                        b_reg     <= sw_sync_reg;
                        state_reg <= S_OP;
                        phase_reg <= 2'b10;
                    end
                end
                S_OP: begin
                    if (enter_p) begin
                        op_reg    <= sw_sync_reg[2:0];
                        state_reg <= S_EXEC;
                        phase_reg <= 2'b11;
                    end
                end
                // Give calc_out one cycle to settle on the freshly registered op.
                S_EXEC: begin
                    result_reg       <= bus.calc_out;
                    result_valid_reg <= 1'b1;
                    state_reg        <= S_SHOW;
                    phase_reg        <= 2'b11;
                end
                S_SHOW: begin
                    if (enter_p) begin
                        result_valid_reg <= 1'b0;
                        state_reg        <= S_A;
                        phase_reg        <= 2'b00;
                    end
                end
                default: begin
                    state_reg <= S_A;
                    phase_reg <= 2'b00;
                end
            endcase
        end
    end

    assign bus.a            = a_reg;
    assign bus.b            = b_reg;
    assign bus.op           = op_reg;
    assign bus.result       = result_reg;
    assign bus.result_valid = result_valid_reg;
    assign bus.phase        = phase_reg;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Directed bench for calc_input_sequencer with a small calculator model as load.
module tb_calc_input_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    calc_input_sequencer_if bus ();

    calc_input_sequencer #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Calculator load: 100=ADD, 110=MULT, others simple logic ops.
    always_comb begin
        logic [7:0] prod;
        prod = bus.a * bus.b;
        case (bus.op)
            3'b100:  bus.calc_out = bus.a + bus.b;
            3'b110:  bus.calc_out = prod[3:0];
            3'b000:  bus.calc_out = bus.a & bus.b;
            3'b001:  bus.calc_out = bus.a | bus.b;
            default: bus.calc_out = bus.a ^ bus.b;
        endcase
    end

    typedef struct {
        logic [3:0] sw_a;
        logic [3:0] sw_b;
        logic [3:0] sw_op;
        logic [2:0] exp_op;
        logic [3:0] exp_result;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] sw, input logic enter, input logic clear, input int n);
        @(negedge clk);
        bus.sw        = sw;
        bus.btn_enter = enter;
        bus.btn_clear = clear;
        repeat (n) @(negedge clk);
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " a"}, {4'h0, bus.a}, 8'h00);
        check({tag, " b"}, {4'h0, bus.b}, 8'h00);
        check({tag, " op"}, {5'h0, bus.op}, 8'h00);
        check({tag, " result"}, {4'h0, bus.result}, 8'h00);
        check({tag, " valid"}, {7'h0, bus.result_valid}, 8'h00);
        check({tag, " phase"}, {6'h0, bus.phase}, 8'h00);
    endtask

    task automatic run_vec(input int i);
        press(vecs[i].sw_a, 1'b1, 1'b0, 10);
        check($sformatf("v%0d phase after A", i), {6'h0, bus.phase}, 8'h01);
        press(vecs[i].sw_b, 1'b1, 1'b0, 10);
        check($sformatf("v%0d phase after B", i), {6'h0, bus.phase}, 8'h02);
        press(vecs[i].sw_op, 1'b1, 1'b0, 10);
        check($sformatf("v%0d a", i), {4'h0, bus.a}, {4'h0, vecs[i].sw_a});
        check($sformatf("v%0d b", i), {4'h0, bus.b}, {4'h0, vecs[i].sw_b});
        check($sformatf("v%0d op", i), {5'h0, bus.op}, {5'h0, vecs[i].exp_op});
        check($sformatf("v%0d result", i), {4'h0, bus.result}, {4'h0, vecs[i].exp_result});
        check($sformatf("v%0d valid", i), {7'h0, bus.result_valid}, 8'h01);
        check($sformatf("v%0d phase show", i), {6'h0, bus.phase}, 8'h03);
        $display("vec %0d: a=%0h b=%0h op=%b result=%0h", i, bus.a, bus.b, bus.op, bus.result);
        press(4'h0, 1'b1, 1'b0, 10);
        check($sformatf("v%0d phase back", i), {6'h0, bus.phase}, 8'h00);
        check($sformatf("v%0d valid cleared", i), {7'h0, bus.result_valid}, 8'h00);
        check($sformatf("v%0d a retained", i), {4'h0, bus.a}, {4'h0, vecs[i].sw_a});
    endtask

    initial begin
        vecs[0] = '{sw_a: 4'h3, sw_b: 4'h5, sw_op: 4'h4, exp_op: 3'b100, exp_result: 4'h8};
        vecs[1] = '{sw_a: 4'h7, sw_b: 4'h3, sw_op: 4'hE, exp_op: 3'b110, exp_result: 4'h5};
        vecs[2] = '{sw_a: 4'h9, sw_b: 4'h9, sw_op: 4'h4, exp_op: 3'b100, exp_result: 4'h2};
        vecs[3] = '{sw_a: 4'hF, sw_b: 4'hF, sw_op: 4'h6, exp_op: 3'b110, exp_result: 4'h1};

        bus.sw = 4'h0;
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;

        // Reset with bouncing buttons.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.btn_enter = ~bus.btn_enter;
            bus.btn_clear = (i == 1);
        end
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_zero("reset");
        $display("reset: phase=%b a=%0h", bus.phase, bus.a);

        // Glitches of 1..3 clocks must be ignored.
        for (int g = 1; g <= 3; g++) begin
            press(4'h9, 1'b1, 1'b0, g);
            check($sformatf("glitch%0d phase", g), {6'h0, bus.phase}, 8'h00);
            check($sformatf("glitch%0d a", g), {4'h0, bus.a}, 8'h00);
        end
        press(4'h9, 1'b1, 1'b0, 10);
        check("long press phase", {6'h0, bus.phase}, 8'h01);
        check("long press a", {4'h0, bus.a}, 8'h09);
        press(4'h2, 1'b1, 1'b0, 10);
        check("b capture", {4'h0, bus.b}, 8'h02);
        check("phase op", {6'h0, bus.phase}, 8'h02);

        // Simultaneous ENTER and CLEAR in S_OP: clear wins.
        press(4'h6, 1'b1, 1'b1, 10);
        check_zero("enter+clear");
        $display("enter+clear: phase=%b a=%0h op=%b", bus.phase, bus.a, bus.op);

        for (int i = 0; i < 4; i++) run_vec(i);

        // Reset mid-entry while in S_B.
        press(4'h5, 1'b1, 1'b0, 10);
        check("mid phase B", {6'h0, bus.phase}, 8'h01);
        check("mid a", {4'h0, bus.a}, 8'h05);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid reset phase", {6'h0, bus.phase}, 8'h00);
        check("mid reset a", {4'h0, bus.a}, 8'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        $display("reset mid-entry: phase=%b a=%0h", bus.phase, bus.a);
        run_vec(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
